// File: rtl/ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_decoder_mux
//  Purpose  : AHB-Lite address decoder and response multiplexer for one
//             manager and REGIONS subordinates. The address phase is decoded
//             combinationally; a data-phase register steers HREADY/HRESP/
//             HRDATA back from the selected target. A built-in default
//             subordinate answers unmapped accesses with a two-cycle ERROR.
//             Optional hang timeout: define AHB_DECODER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_decoder_mux #(
  parameter int                            DATA_WIDTH     = 32,
  parameter int                            ADDR_WIDTH     = 32,
  parameter int                            REGIONS        = 4,
  parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_BASE    = {REGIONS{32'h0}},
  parameter logic [REGIONS*ADDR_WIDTH-1:0] REGION_SIZE    = {REGIONS{32'h0010_0000}},
  parameter int                            IDLE_ENABLE    = 1,
  parameter logic [ADDR_WIDTH-1:0]         IDLE_BASEADDR  = 32'hE000_0000,
  parameter logic [ADDR_WIDTH-1:0]         IDLE_SIZE      = 32'h2000_0000,
  parameter int                            TIMEOUT_CYCLES = 1024
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  // upstream (manager side)
  input  logic                          S_HSEL,
  input  logic [ADDR_WIDTH-1:0]         S_HADDR,
  input  logic                          S_HWRITE,
  input  logic [2:0]                    S_HSIZE,
  input  logic [2:0]                    S_HBURST,
  input  logic [3:0]                    S_HPROT,
  input  logic [1:0]                    S_HTRANS,
  input  logic                          S_HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]         S_HWDATA,
  input  logic                          S_HMASTER,
  output logic                          S_HREADY,
  output logic                          S_HRESP,
  output logic [DATA_WIDTH-1:0]         S_HRDATA,
  // downstream (subordinate side)
  output logic [REGIONS-1:0]            M_HSEL,
  output logic [ADDR_WIDTH-1:0]         M_HADDR,
  output logic                          M_HWRITE,
  output logic [2:0]                    M_HSIZE,
  output logic [2:0]                    M_HBURST,
  output logic [3:0]                    M_HPROT,
  output logic [1:0]                    M_HTRANS,
  output logic                          M_HMASTLOCK,
  output logic [DATA_WIDTH-1:0]         M_HWDATA,
  output logic                          M_HREADYIN,
  input  logic [REGIONS-1:0]            M_HREADY,
  input  logic [REGIONS-1:0]            M_HRESP,
  input  logic [REGIONS*DATA_WIDTH-1:0] M_HRDATA,
  output logic [REGIONS-1:0]            M_TIMEOUT
);

  // Default-subordinate states
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_err1 = 2'd1;
  localparam logic [1:0] c_st_err2 = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_idle_mask = ~(IDLE_SIZE - ADDR_WIDTH'(1));

  // Elaboration-time parameter sanity
  if (REGIONS < 1 || REGIONS > 16) begin : g_chk_regions
    $error("ahb_decoder_mux: REGIONS must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("ahb_decoder_mux: TIMEOUT_CYCLES must be at least 2");
  end

  logic [REGIONS-1:0]    w_hit;
  logic [REGIONS-1:0]    w_sel;
  logic [REGIONS-1:0]    w_blocked;
  logic [REGIONS-1:0]    w_dsel_next;
  logic                  w_any_hit;
  logic                  w_idle_hit;
  logic                  w_active;
  logic                  w_dflt_next;
  logic                  w_dok_next;
  logic                  w_abort;
  logic                  w_sel_ready;
  logic                  w_sel_resp;
  logic [DATA_WIDTH-1:0] w_sel_rdata;

  logic [REGIONS-1:0]    r_dsel;
  logic                  r_dflt;
  logic                  r_dok;
  logic [1:0]            r_state;

  // Address-phase region match; regions flagged by the timeout logic are
  // treated as unmapped.
  for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
    localparam logic [ADDR_WIDTH-1:0] c_base = REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] c_mask =
      ~(REGION_SIZE[gi*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(1));
    assign w_hit[gi] = S_HSEL && !w_blocked[gi] && ((S_HADDR & c_mask) == c_base);
  end

  // Isolate the lowest set bit so overlapping regions resolve to the lowest index
  assign w_sel      = w_hit & (~w_hit + REGIONS'(1));
  assign w_any_hit  = |w_hit;
  assign w_idle_hit = (IDLE_ENABLE != 0) && S_HSEL && ((S_HADDR & c_idle_mask) == IDLE_BASEADDR);
  assign w_active   = S_HSEL && S_HTRANS[1];

  assign w_dsel_next = w_active ? w_sel : '0;
  assign w_dflt_next = w_active && !w_any_hit && !w_idle_hit && !S_HMASTER;
  assign w_dok_next  = S_HSEL && !w_any_hit && !w_dflt_next;

  // Broadcast copies of the upstream address/control/data
  assign M_HSEL      = w_sel;
  assign M_HADDR     = S_HADDR;
  assign M_HWRITE    = S_HWRITE;
  assign M_HSIZE     = S_HSIZE;
  assign M_HBURST    = S_HBURST;
  assign M_HPROT     = S_HPROT;
  assign M_HTRANS    = S_HTRANS;
  assign M_HMASTLOCK = S_HMASTLOCK;
  assign M_HWDATA    = S_HWDATA;
  assign M_HREADYIN  = S_HREADY;

  // Pick the response of the region that owns the current data phase
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_resp  = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < REGIONS; i++) begin
      if (r_dsel[i]) begin
        w_sel_ready = M_HREADY[i];
        w_sel_resp  = M_HRESP[i];
        w_sel_rdata = M_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef AHB_DECODER_TIMEOUT_EN
  localparam int                 c_wcnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_wcnt_w-1:0] r_wcnt;
  logic [REGIONS-1:0]  r_timeout;
  logic                w_stall;

  assign w_stall   = (|r_dsel) && !w_sel_ready;
  assign w_abort   = w_stall && (r_wcnt == c_wcnt_last);
  assign w_blocked = r_timeout;
  assign M_TIMEOUT = r_timeout;

  // Count consecutive wait states; on expiry flag the stuck region for good
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wcnt    <= '0;
      r_timeout <= '0;
    end else begin
      if (!w_stall || w_abort) r_wcnt <= '0;
      else                     r_wcnt <= r_wcnt + c_wcnt_w'(1);
      if (w_abort) r_timeout <= r_timeout | r_dsel;
    end
  end
`else
  assign w_abort   = 1'b0;
  assign w_blocked = '0;
  assign M_TIMEOUT = '0;
`endif

  // Data-phase tracking and default-subordinate sequencing
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dsel  <= '0;
      r_dflt  <= 1'b0;
      r_dok   <= 1'b0;
      r_state <= c_st_idle;
    end else if (w_abort) begin
      // A hung region is dropped and the manager gets an ERROR instead
      r_dsel  <= '0;
      r_dflt  <= 1'b1;
      r_dok   <= 1'b0;
      r_state <= c_st_err1;
    end else if (S_HREADY) begin
      // ERR2 drives HREADY high, so a transfer issued then is decoded here
      r_dsel  <= w_dsel_next;
      r_dflt  <= w_dflt_next;
      r_dok   <= w_dok_next;
      r_state <= w_dflt_next ? c_st_err1 : c_st_idle;
    end else if (r_state == c_st_err1) begin
      r_state <= c_st_err2;
    end
  end

  // Response mux back to the manager
  always_comb begin
    S_HREADY = 1'b1;
    S_HRESP  = 1'b0;
    S_HRDATA = '0;
    if (|r_dsel) begin
      S_HREADY = w_sel_ready;
      S_HRESP  = w_sel_resp;
      S_HRDATA = w_sel_rdata;
    end else if (r_dflt) begin
      S_HREADY = (r_state == c_st_err2);
      S_HRESP  = 1'b1;
    end else if (r_dok) begin
      S_HREADY = 1'b1;
      S_HRESP  = 1'b0;
      S_HRDATA = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_decoder_mux
//  Purpose  : Self-checking bench for ahb_decoder_mux (REGIONS=4). Expected
//             transfer results are queued when a transfer is issued and
//             popped when its data phase completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder_mux;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 4;

  // region 3 overlaps region 1 on purpose (lowest index must win)
  localparam logic [NR*AW-1:0] c_base = {32'h4000_0000, 32'h5000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NR*AW-1:0] c_size = {32'h4000_0000, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000};

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          S_HSEL, S_HWRITE, S_HMASTLOCK, S_HMASTER;
  logic [AW-1:0] S_HADDR;
  logic [2:0]    S_HSIZE, S_HBURST;
  logic [3:0]    S_HPROT;
  logic [1:0]    S_HTRANS;
  logic [DW-1:0] S_HWDATA;
  logic          S_HREADY, S_HRESP;
  logic [DW-1:0] S_HRDATA;
  logic [NR-1:0] M_HSEL;
  logic [AW-1:0] M_HADDR;
  logic          M_HWRITE, M_HMASTLOCK, M_HREADYIN;
  logic [2:0]    M_HSIZE, M_HBURST;
  logic [3:0]    M_HPROT;
  logic [1:0]    M_HTRANS;
  logic [DW-1:0] M_HWDATA;
  logic [NR-1:0] M_HREADY, M_HRESP, M_TIMEOUT;
  logic [NR*DW-1:0] M_HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_decoder_mux #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REGIONS(NR),
    .REGION_BASE(c_base), .REGION_SIZE(c_size),
    .IDLE_ENABLE(1), .IDLE_BASEADDR(32'hE000_0000), .IDLE_SIZE(32'h2000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HTRANS(S_HTRANS),
    .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HMASTER(S_HMASTER),
    .S_HREADY(S_HREADY), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HTRANS(M_HTRANS),
    .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA), .M_HREADYIN(M_HREADYIN),
    .M_HREADY(M_HREADY), .M_HRESP(M_HRESP), .M_HRDATA(M_HRDATA),
    .M_TIMEOUT(M_TIMEOUT)
  );

  // One completed transfer: finished flag, address-phase M_HSEL, wait states,
  // HRESP on first and last data-phase cycle, read data on the last cycle.
  typedef struct packed {
    logic        done;
    logic [3:0]  hsel;
    logic [7:0]  waits;
    logic        rf;
    logic        rl;
    logic [31:0] data;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] c_d0 = 32'h1111_0000;
  localparam logic [31:0] c_d1 = 32'hCAFE_F00D;
  localparam logic [31:0] c_d2 = 32'h2222_BEEF;
  localparam logic [31:0] c_d3 = 32'h3333_5555;

  // Data phase: stall `region` for `waits` cycles, then watch until HREADY.
  task automatic data_phase(input int region, input int waits, output res_t r);
    int w;
    r = '0;
    w = 0;
    if (region >= 0 && waits > 0) M_HREADY[region] = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #4;
      if (c == 0) r.rf = S_HRESP;
      if (S_HREADY === 1'b1) begin
        r.done = 1'b1;
        r.rl   = S_HRESP;
        r.data = S_HRDATA;
        break;
      end
      w++;
      @(posedge HCLK); #1;
      if (region >= 0 && w >= waits) M_HREADY[region] = 1'b1;
    end
    r.waits = 8'(w);
  endtask

  // Single transfer: address phase then data phase with an idle bus behind it
  task automatic xfer(input logic [31:0] addr, input logic [1:0] trans, input logic master,
                      input int region, input int waits, output res_t r);
    logic [3:0] hs;
    @(posedge HCLK); #1;
    S_HSEL = 1'b1; S_HADDR = addr; S_HTRANS = trans; S_HMASTER = master;
    #4 hs = M_HSEL;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HMASTER = 1'b0;
    data_phase(region, waits, r);
    r.hsel = hs;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    S_HSEL = 0; S_HADDR = '0; S_HWRITE = 0; S_HSIZE = 3'd2; S_HBURST = 0; S_HPROT = 4'h3;
    S_HTRANS = 0; S_HMASTLOCK = 0; S_HWDATA = '0; S_HMASTER = 0;
    M_HREADY = '1; M_HRESP = '0;
    M_HRDATA = {c_d3, c_d2, c_d1, c_d0};
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if ({S_HREADY, S_HRESP, S_HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_outputs: got %b/%b/%h expected 1/0/00000000", S_HREADY, S_HRESP, S_HRDATA);
    end
    checks++;
    if (M_TIMEOUT !== 4'b0000) begin
      errors++; $display("FAIL reset_timeout: got %b expected 0000", M_TIMEOUT);
    end
    HRESETn = 1'b1;
    S_HADDR = 32'h1234_5678; S_HWDATA = 32'hA5A5_0F0F;
    @(posedge HCLK); #1;
    checks++;
    if (M_HSEL !== 4'b0000 || M_HREADYIN !== 1'b1) begin
      errors++; $display("FAIL idle_bus: got hsel=%b readyin=%b expected 0000/1", M_HSEL, M_HREADYIN);
    end
    checks++;
    if (M_HADDR !== 32'h1234_5678 || M_HWDATA !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL broadcast: got %h/%h expected 12345678/a5a50f0f", M_HADDR, M_HWDATA);
    end
    S_HADDR = '0; S_HWDATA = '0;
  endtask

  task automatic test_region_read();
    res_t r, e;
    sb.push_back('{1'b1, 4'b0010, 8'd0, 1'b0, 1'b0, c_d1});
    xfer(32'h4000_0010, 2'b10, 1'b0, 1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL region_read: got %h expected %h", r, e); end
    sb.push_back('{1'b1, 4'b1000, 8'd0, 1'b0, 1'b0, c_d3});
    xfer(32'h6000_0040, 2'b11, 1'b0, 3, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL region3_read: got %h expected %h", r, e); end
  endtask

  task automatic test_wait_states();
    res_t r, e;
    sb.push_back('{1'b1, 4'b0100, 8'd3, 1'b0, 1'b0, c_d2});
    xfer(32'h5000_0020, 2'b10, 1'b0, 2, 3, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL wait_states: got %h expected %h", r, e); end
  endtask

  task automatic test_default_error();
    res_t r, e;
    sb.push_back('{1'b1, 4'b0000, 8'd1, 1'b1, 1'b1, 32'h0});
    xfer(32'h9000_0000, 2'b10, 1'b0, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL default_error: got %h expected %h", r, e); end
    sb.push_back('{1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 32'h0});
    xfer(32'h9000_0000, 2'b10, 1'b1, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL debugger_miss: got %h expected %h", r, e); end
  endtask

  task automatic test_idle_window();
    res_t r, e;
    sb.push_back('{1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 32'h0});
    xfer(32'hE000_1000, 2'b10, 1'b0, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL idle_window: got %h expected %h", r, e); end
    sb.push_back('{1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 32'h0});
    xfer(32'h9000_0000, 2'b00, 1'b0, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL idle_trans_miss: got %h expected %h", r, e); end
    // M_HSEL follows the address regardless of HTRANS, but no data phase follows
    sb.push_back('{1'b1, 4'b0100, 8'd0, 1'b0, 1'b0, 32'h0});
    xfer(32'h5000_0000, 2'b00, 1'b0, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL idle_trans_hit: got %h expected %h", r, e); end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    @(posedge HCLK); #1;
    S_HSEL = 1'b1; S_HADDR = 32'h9000_0004; S_HTRANS = 2'b10;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00;
    #4; checks++;
    if ({S_HREADY, S_HRESP} !== 2'b01) begin
      errors++; $display("FAIL b2b_err1: got ready/resp %b%b expected 01", S_HREADY, S_HRESP);
    end
    @(posedge HCLK); #1;
    S_HSEL = 1'b1; S_HADDR = 32'h4000_0010; S_HTRANS = 2'b10;
    sb.push_back('{1'b1, 4'b0010, 8'd0, 1'b0, 1'b0, c_d1});
    #4; checks++;
    if ({S_HREADY, S_HRESP, M_HSEL} !== 6'b11_0010) begin
      errors++; $display("FAIL b2b_err2: got %b%b hsel=%b expected 11 hsel=0010", S_HREADY, S_HRESP, M_HSEL);
    end
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00;
    data_phase(1, 0, r);
    r.hsel = 4'b0010;
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL b2b_read: got %h expected %h", r, e); end
  endtask

  task automatic test_reset_mid_wait();
    res_t r, e;
    @(posedge HCLK); #1;
    S_HSEL = 1'b1; S_HADDR = 32'h5000_0000; S_HTRANS = 2'b10;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00; M_HREADY[2] = 1'b0;
    #4; checks++;
    if (S_HREADY !== 1'b0) begin errors++; $display("FAIL pre_reset_wait: got %b expected 0", S_HREADY); end
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1; checks++;
    if ({S_HREADY, S_HRESP, S_HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL async_reset: got %b/%b/%h expected 1/0/00000000", S_HREADY, S_HRESP, S_HRDATA);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1; M_HREADY[2] = 1'b1;
    sb.push_back('{1'b1, 4'b0010, 8'd0, 1'b0, 1'b0, c_d1});
    xfer(32'h4000_0010, 2'b10, 1'b0, 1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL post_reset_read: got %h expected %h", r, e); end
  endtask

`ifdef AHB_DECODER_TIMEOUT_EN
  task automatic test_timeout();
    res_t r, e;
    // 8 stalled cycles, then ERR1 (low) and ERR2 (high), HRESP=1 on both
    sb.push_back('{1'b1, 4'b1000, 8'd9, 1'b0, 1'b1, 32'h0});
    xfer(32'h6000_0100, 2'b10, 1'b0, 3, 1000, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL timeout_abort: got %h expected %h", r, e); end
    M_HREADY[3] = 1'b1;
    checks++;
    if (M_TIMEOUT !== 4'b1000) begin errors++; $display("FAIL timeout_flag: got %b expected 1000", M_TIMEOUT); end
    sb.push_back('{1'b1, 4'b0000, 8'd1, 1'b1, 1'b1, 32'h0});
    xfer(32'h6000_0000, 2'b10, 1'b0, -1, 0, r);
    e = sb.pop_front(); checks++;
    if (r !== e) begin errors++; $display("FAIL timeout_blocked: got %h expected %h", r, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_region_read();
    test_wait_states();
    test_default_error();
    test_idle_window();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef AHB_DECODER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
